i2c_slave_regs: RTL and testbench
=================================

# i2c_slave_regs

Synthesizable I2C slave with an internal byte-wide register file. It sits directly downstream of the `I2C_TOP` master on the shared `scl_out`/`i2c_sda` bus and replaces the behavioural slave model in system simulation and on silicon. The master addresses it with a 7-bit address, writes a register pointer, then reads or writes bytes with pointer auto-increment. Register contents are also visible to local logic through a parallel read port and a write-event strobe.

## Interface

**Parameters**
- `SLAVE_ADDR`, 7'h10: 7-bit bus address this slave acknowledges.
- `NUM_REGS`, 16: register-file depth. Must be a power of two, 2..256.
- `PTR_W`, $clog2(NUM_REGS): pointer width.

**Ports**
- `clk`, input, 1: system clock. Its frequency must be ≥ 16× the SCL frequency.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `scl`, input, 1: raw bus SCL. Asynchronous to `clk`.
- `sda_in`, input, 1: raw bus SDA. Asynchronous to `clk`.
- `sda_oe`, output, 1: 1 pulls SDA low. The top level implements open-drain (`assign i2c_sda = sda_oe ? 1'b0 : 1'bz`).
- `loc_addr`, input, PTR_W: local parallel read address.
- `loc_data`, output, 8: `regs[loc_addr]`, combinational.
- `wr_strobe`, output, 1: one-cycle pulse per bus-written register byte.
- `wr_addr`, output, PTR_W: register index written. Valid with `wr_strobe`.
- `wr_data`, output, 8: byte written. Valid with `wr_strobe`.
- `busy`, output, 1: high from an addressed START until STOP or NACK-release.

## Operation

**Input conditioning**
- `scl` and `sda_in` each pass through a 2-FF synchronizer plus a previous-value register.
- Rise and fall events are derived from the synchronized signals.

**Bus conditions**
- START: synchronized SDA falls while synchronized SCL is high. Valid in any state; a repeated START re-enters ADDR.
- STOP: SDA rises while SCL is high. Goes to IDLE from any state.

**Bit timing**
- Bits are sampled on the SCL rise event, MSB first.
- The slave changes `sda_oe` only on the SCL fall event.

**States**
- IDLE: wait for START.
- ADDR: shift 8 bits (7-bit address + R/W).
  - On match, enter ADDR_ACK.
  - On mismatch, enter WAIT_STOP with `sda_oe`=0.
- ADDR_ACK: drive low for the 9th clock. Then go to PTR if R/W=0, or RDATA if R/W=1.
- PTR: receive the pointer byte, keeping the low PTR_W bits. Then PTR_ACK (always ACK), then WDATA.
- WDATA: receive a byte, then go to WDATA_ACK.
  - On the 8th sampled bit: `regs[ptr]` ← byte, `wr_strobe` pulses, ptr ← ptr+1 mod NUM_REGS.
  - WDATA_ACK always ACKs.
- RDATA: load the shift register with `regs[ptr]` on the fall event that ends ADDR_ACK or RDATA_ACK.
  - Drive `sda_oe` = ~bit, MSB first.
  - ptr increments once the byte has been shifted out.
- RDATA_ACK: release SDA and sample the master's bit on the 9th rise.
  - ACK (0) → RDATA.
  - NACK (1) → WAIT_STOP.
- WAIT_STOP: `sda_oe`=0. Ignore everything except START and STOP.

**Pointer**
- The pointer persists across transactions, so a write of the pointer alone followed by a repeated-START read reads from that pointer.
- The pointer resets to 0.

**Boundary conditions**
- STOP or START in the middle of a byte aborts the byte: no register write and no strobe.
- Pointer wrap: index NUM_REGS-1 is followed by index 0.
- Simultaneous bus write and `loc_addr` read of the same register: `loc_data` shows the old value in the write cycle and the new value afterwards.

## Timing

**Reset values**
- `sda_oe`=0, `wr_strobe`=0, `busy`=0, `wr_addr`=0, `wr_data`=0.
- All regs 0, ptr 0, state IDLE.
- Synchronizers are cleared to 1 (bus idle).
- Asserting `rst` mid-transaction releases SDA on the next edge; the slave then waits for a fresh START.

**Latencies**
- Pin to detected event: 3 `clk` cycles (2 sync + edge).
- `sda_oe` update: 1 cycle after the SCL fall event (4 cycles after the SCL pin fall). This is well inside the low half-period at the 16× ratio.
- `wr_strobe`: asserted the cycle after the 8th data-bit rise event, for exactly 1 cycle.
- `wr_addr` and `wr_data` hold their value until the next strobe.
- `busy`:
  - rises the cycle after an address-match decision;
  - falls the cycle after STOP or a NACK.

## Structure

**Shared package `i2c_pkg`**
- State enum: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Constants: `I2C_RW_WRITE`=0, `I2C_RW_READ`=1, `I2C_ACK`=0, `I2C_NACK`=1.
- `I2C_TOP` reuses the same package.

**Sub-module `i2c_sync_edge`**
- 2-FF synchronizer with rise/fall pulse outputs, reset to 1.
- Instantiated twice, once for `scl` and once for `sda_in`.

**Top module**
- FSM, bit counter (0..8), shift register, pointer, register array.

## Test plan

1. **Write with auto-increment**
   - Stimulus: START, 0x20 (0x10+W), pointer 0x03, data 0xA5, 0x5A, STOP.
   - Required response: four ACKs; regs[3]=0xA5 and regs[4]=0x5A; two `wr_strobe` pulses with (3,0xA5) and (4,0x5A); `busy` low after STOP.
2. **Read after repeated START**
   - Stimulus: write pointer 0x03, repeated START, 0x21; master ACKs byte 1 and NACKs byte 2.
   - Required response: bytes 0xA5 then 0x5A on SDA; `sda_oe`=0 after the NACK; ptr=5.
3. **Wrong address**
   - Stimulus: 0x22 (0x11+W) followed by two bytes.
   - Required response: `sda_oe` never asserted; no strobes; `busy` stays 0.
4. **Pointer wrap**
   - Stimulus: pointer 0x0F, write 0x11, 0x22, 0x33.
   - Required response: regs[15]=0x11, regs[0]=0x22, regs[1]=0x33.
5. **Aborted byte**
   - Stimulus: STOP after 4 data bits.
   - Required response: register unchanged, no `wr_strobe`. A following write transaction succeeds.
6. **Reset mid-read**
   - Stimulus: assert `rst` for 1 cycle while `sda_oe`=1.
   - Required response: `sda_oe`=0 the next cycle; regs and ptr=0; a new transaction is acknowledged normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller states, bus-level constants and small helpers.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned ADDR_W    = 7;

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  // Address byte is {addr[6:0], rw}
  function automatic logic addr_hit(input logic [BYTE_W-1:0] b, input logic [ADDR_W-1:0] a);
    return b[BYTE_W-1:1] == a;
  endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Raw I2C bus pins as seen by a slave: SCL, wired SDA level and the SDA pull-down enable.
interface i2c_slave_regs_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl, input sda_in, output sda_oe);
  modport master (output scl, output sda_in, input sda_oe);
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with registered previous value; rise/fall pulses last one clk.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with a byte-wide register file, auto-incrementing pointer,
// local parallel read port and a write-event strobe.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h10,
  parameter int unsigned       NUM_REGS   = 16,
  parameter int unsigned       PTR_W      = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  i2c_slave_regs_if.slave    bus,
  input  logic [PTR_W-1:0]   loc_addr,
  output logic [BYTE_W-1:0]  loc_data,
  output logic               wr_strobe,
  output logic [PTR_W-1:0]   wr_addr,
  output logic [BYTE_W-1:0]  wr_data,
  output logic               busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk(clk), .rst(rst), .d_i(bus.scl),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk(clk), .rst(rst), .d_i(bus.sda_in),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 strobe_q, strobe_d;
  logic [PTR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]    wr_data_q, wr_data_d;
  logic [BYTE_W-1:0]    regs_q [NUM_REGS];
  logic                 reg_we;
  logic [BYTE_W-1:0]    rx_byte;
  logic [BYTE_W-1:0]    rd_byte;

  assign rx_byte = {shift_q[BYTE_W-2:0], sda_lvl};
  assign rd_byte = regs_q[ptr_q];

  // Next-state and output logic; bus conditions override the per-state behaviour
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              cnt_d = '0;
              if (state_q == ADDR) begin
                if (addr_hit(rx_byte, SLAVE_ADDR)) begin
                  state_d = ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                reg_we    = 1'b1;
                strobe_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = WDATA_ACK;
              end
            end
          end
        end
        // cnt_q marks whether the 9th rise has been seen
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_rise) begin
            cnt_d = BIT_CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt_q == '0) begin
              sda_oe_d = 1'b1;
            end else begin
              cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
                state_d  = RDATA;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[BYTE_W-1];
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              cnt_d   = '0;
              ptr_d   = ptr_q + PTR_W'(1);
              state_d = RDATA_ACK;
            end
          end else if (scl_fall) begin
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[BYTE_W-2];
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              cnt_d = BIT_CNT_W'(1);
            end
          end else if (scl_fall) begin
            if (cnt_q == '0) begin
              sda_oe_d = 1'b0;
            end else begin
              cnt_d    = '0;
              state_d  = RDATA;
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[BYTE_W-1];
            end
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        IDLE:      sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (reg_we) regs_q[ptr_q] <= rx_byte;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign loc_data   = regs_q[loc_addr];
  assign wr_strobe  = strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master exercising i2c_slave_regs with directed vectors and corner-case sequences.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_regs_if bus();
  assign bus.scl    = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  logic [3:0] loc_addr;
  logic [7:0] loc_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  i2c_slave_regs #(.SLAVE_ADDR(7'h10), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .loc_addr(loc_addr), .loc_data(loc_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Passive monitor: strobe log and activity counters
  logic [3:0] sa [$];
  logic [7:0] sd [$];
  int oe_cnt = 0, busy_cnt = 0, dbl_strobe = 0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (wr_strobe) begin
      sa.push_back(wr_addr);
      sd.push_back(wr_data);
    end
    if (wr_strobe && prev_strobe) dbl_strobe++;
    prev_strobe = wr_strobe;
    if (bus.sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = bus.sda_in; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit);
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [7:0] exp);
    loc_addr = 4'(idx);
    #1;
    check(name, 32'(loc_data), 32'(exp));
  endtask

  task automatic write_txn(input logic [7:0] ptr, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic ack;
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    i2c_start();
    write_byte(8'h20, ack); check("wtx_addr_ack", 32'(ack), 0);
    write_byte(ptr, ack);   check("wtx_ptr_ack", 32'(ack), 0);
    for (int j = 0; j < n; j++) begin
      write_byte(d[j], ack); check("wtx_data_ack", 32'(ack), 0);
    end
    i2c_stop();
    wait_q();
  endtask

  typedef struct {
    logic [7:0] ptr;
    int         n;
    logic [7:0] d [3];
    logic [3:0] a [3];
  } wvec_t;

  wvec_t vec [3];

  initial begin
    fork
      begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
      end
    join_none
  end

  initial begin
    logic ack, b;
    logic [7:0] rb;
    int base, oe0, busy0;

    vec[0].ptr = 8'h0F; vec[0].n = 3;
    vec[0].d = '{8'h11, 8'h22, 8'h33}; vec[0].a = '{4'd15, 4'd0, 4'd1};
    vec[1].ptr = 8'h08; vec[1].n = 2;
    vec[1].d = '{8'hC3, 8'h3C, 8'h00}; vec[1].a = '{4'd8, 4'd9, 4'd0};
    vec[2].ptr = 8'h1A; vec[2].n = 2;
    vec[2].d = '{8'h9A, 8'hBC, 8'h00}; vec[2].a = '{4'd10, 4'd11, 4'd0};

    rst = 1'b1; loc_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", 32'(bus.sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobe", 32'(wr_strobe), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    chk_reg("rst_reg0", 0, 8'h00);
    wait_q();

    // Write with auto-increment
    base = sa.size();
    i2c_start();
    write_byte(8'h20, ack); check("t1_addr_ack", 32'(ack), 0);
    check("t1_busy_high", 32'(busy), 1);
    write_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 0);
    write_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 0);
    write_byte(8'h5A, ack); check("t1_d1_ack", 32'(ack), 0);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_busy_low", 32'(busy), 0);
    check("t1_strobes", 32'(sa.size() - base), 2);
    if (sa.size() - base == 2) begin
      check("t1_s0_addr", 32'(sa[base]), 3);
      check("t1_s0_data", 32'(sd[base]), 32'hA5);
      check("t1_s1_addr", 32'(sa[base+1]), 4);
      check("t1_s1_data", 32'(sd[base+1]), 32'h5A);
    end
    check("t1_wr_addr_hold", 32'(wr_addr), 4);
    check("t1_wr_data_hold", 32'(wr_data), 32'h5A);
    chk_reg("t1_reg3", 3, 8'hA5);
    chk_reg("t1_reg4", 4, 8'h5A);

    write_txn(8'h05, 1, 8'h77, 8'h00, 8'h00);

    // Pointer write, repeated START, read two bytes
    i2c_start();
    write_byte(8'h20, ack); check("t2_addr_ack", 32'(ack), 0);
    write_byte(8'h03, ack); check("t2_ptr_ack", 32'(ack), 0);
    i2c_start();
    write_byte(8'h21, ack); check("t2_raddr_ack", 32'(ack), 0);
    read_byte(1'b0, rb); check("t2_byte0", 32'(rb), 32'hA5);
    read_byte(1'b1, rb); check("t2_byte1", 32'(rb), 32'h5A);
    repeat (6) @(negedge clk);
    check("t2_oe_released", 32'(bus.sda_oe), 0);
    check("t2_busy_nack", 32'(busy), 0);
    i2c_stop();
    i2c_start();
    write_byte(8'h21, ack); check("t2_cur_ack", 32'(ack), 0);
    read_byte(1'b1, rb); check("t2_ptr5", 32'(rb), 32'h77);
    i2c_stop();
    wait_q();

    // Wrong address
    base = sa.size(); oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h22, ack); check("t3_addr_nack", 32'(ack), 1);
    write_byte(8'h01, ack); check("t3_b0_nack", 32'(ack), 1);
    write_byte(8'h02, ack); check("t3_b1_nack", 32'(ack), 1);
    i2c_stop();
    wait_q();
    check("t3_no_oe", 32'(oe_cnt - oe0), 0);
    check("t3_no_busy", 32'(busy_cnt - busy0), 0);
    check("t3_no_strobe", 32'(sa.size() - base), 0);

    // Table-driven writes, including pointer wrap
    for (int i = 0; i < 3; i++) begin
      base = sa.size();
      write_txn(vec[i].ptr, vec[i].n, vec[i].d[0], vec[i].d[1], vec[i].d[2]);
      check("vec_strobes", 32'(sa.size() - base), 32'(vec[i].n));
      if (sa.size() - base == vec[i].n) begin
        for (int j = 0; j < vec[i].n; j++) begin
          check("vec_s_addr", 32'(sa[base+j]), 32'(vec[i].a[j]));
          check("vec_s_data", 32'(sd[base+j]), 32'(vec[i].d[j]));
        end
      end
      for (int j = 0; j < vec[i].n; j++) chk_reg("vec_reg", int'(vec[i].a[j]), vec[i].d[j]);
    end
    chk_reg("wrap_reg15", 15, 8'h11);
    chk_reg("wrap_reg0", 0, 8'h22);

    // STOP after 4 data bits aborts the byte
    base = sa.size();
    i2c_start();
    write_byte(8'h20, ack); check("t5_addr_ack", 32'(ack), 0);
    write_byte(8'h07, ack); check("t5_ptr_ack", 32'(ack), 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    wait_q();
    check("t5_no_strobe", 32'(sa.size() - base), 0);
    check("t5_busy", 32'(busy), 0);
    chk_reg("t5_reg7_kept", 7, 8'h00);
    write_txn(8'h07, 1, 8'h99, 8'h00, 8'h00);
    check("t5_retry_strobe", 32'(sa.size() - base), 1);
    chk_reg("t5_reg7_new", 7, 8'h99);

    // Reset while the slave drives a 0 data bit (regs[8]=C3: 1,1,0...)
    i2c_start();
    write_byte(8'h21, ack); check("t6_addr_ack", 32'(ack), 0);
    read_bit(b); check("t6_bit7", 32'(b), 1);
    read_bit(b); check("t6_bit6", 32'(b), 1);
    check("t6_oe_driving", 32'(bus.sda_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_oe_after_rst", 32'(bus.sda_oe), 0);
    check("t6_busy_after_rst", 32'(busy), 0);
    chk_reg("t6_reg8_cleared", 8, 8'h00);
    chk_reg("t6_reg3_cleared", 3, 8'h00);
    i2c_stop();
    wait_q();
    i2c_start();
    write_byte(8'h21, ack); check("t6_new_ack", 32'(ack), 0);
    read_byte(1'b1, rb); check("t6_read_reg0", 32'(rb), 0);
    i2c_stop();
    wait_q();
    base = sa.size();
    write_txn(8'h02, 1, 8'h5C, 8'h00, 8'h00);
    check("t6_wr_strobe", 32'(sa.size() - base), 1);
    chk_reg("t6_reg2", 2, 8'h5C);

    check("strobe_single_cycle", 32'(dbl_strobe), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
